// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB blocks: the initiator FSM state encoding,
// transfer direction constants and default bus widths / timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;

    localparam int APB_ADDR_W_DEF  = 2;
    localparam int APB_DATA_W_DEF  = 8;
    localparam int APB_TIMEOUT_DEF = 16;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles in which the slave holds pready low and flags the
// terminal count TIMEOUT-1, at which the initiator aborts the transfer.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   clr_i  : clear the count (asserted on the cycle before ACCESS is entered)
//   en_i   : increment (stalled ACCESS cycle)
//   tc_o   : count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int              CW     = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]   TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Stall counter; holds at the terminal count so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule : apb_wait_timer

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB initiator: turns a valid/ready command into an APB SETUP/ACCESS transfer
// and reports completion on a one-cycle registered response strobe. One
// transfer outstanding; a new command may be accepted on the completion cycle
// so that SETUP follows ACCESS directly with psel held high.
// Ports:
//   pclk, preset           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata   : command payload
//   rsp_valid/rdata/err/timeout : registered response, valid for one cycle
//   psel/penable/paddr/pwrite/pwdata : APB request (registered)
//   prdata/pready/pslverr  : APB slave response
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W_DEF,
    parameter int DATA_W  = APB_DATA_W_DEF,
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;

    logic              tc;
    logic              in_access;
    logic              done;
    logic              abort;
    logic              accept;

    // pready has priority over the terminal count: abort only when still stalled.
    assign in_access = (state_q == ACCESS);
    assign done      = in_access & (pready | tc);
    assign abort     = in_access & ~pready & tc;
    assign cmd_ready = (state_q == IDLE) | done;
    assign accept    = cmd_valid & cmd_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i (pclk),
        .rst_i (preset),
        .clr_i (state_q == SETUP),
        .en_i  (in_access & ~pready),
        .tc_o  (tc)
    );

    // Response payload for the completion cycle; prdata/pslverr are ignored otherwise.
    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (done && pready && (pwrite_q == APB_READ)) begin
            rsp_rdata_d = prdata;
        end else begin
            rsp_rdata_d = '0;
        end
        if (done) begin
            rsp_err_d = (pready & pslverr) | abort;
        end else begin
            rsp_err_d = 1'b0;
        end
    end

    // Transfer FSM with registered APB outputs and response strobe.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= done;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= abort;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    psel_q    <= 1'b1;
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        if (accept) begin
                            // Chain straight into the next SETUP; psel stays high.
                            paddr_q   <= cmd_addr;
                            pwrite_q  <= cmd_write;
                            pwdata_q  <= cmd_wdata;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            state_q   <= SETUP;
                        end else begin
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge (ADDR_W=2, DATA_W=8, TIMEOUT=16).
// A behavioural APB slave answers ACCESS cycles after a programmable number of
// wait states; expected responses are queued when a command is driven and
// compared against responses captured from the DUT.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = 2'd0;
    logic [DW-1:0] cmd_wdata = 8'h00;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = 8'h00;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   obs_cyc_q[$];

    // slave model configuration
    int            slv_waits = 0;
    logic          slv_never = 1'b0;
    logic [DW-1:0] slv_rdata = 8'h00;
    logic          slv_err   = 1'b0;
    int            acc_cnt   = 0;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    // cycle counter
    always @(posedge pclk) cyc <= cyc + 1;

    // APB slave: garbage on prdata/pslverr except in the completion cycle
    always @(negedge pclk) begin
        if (psel === 1'b1 && penable === 1'b1) begin
            pready  = !slv_never && (acc_cnt == slv_waits);
            prdata  = pready ? slv_rdata : 8'hEE;
            pslverr = pready ? slv_err : 1'b1;
            acc_cnt = acc_cnt + 1;
        end else begin
            pready  = 1'b0;
            prdata  = 8'h55;
            pslverr = 1'b1;
            acc_cnt = 0;
        end
    end

    // response monitor
    always @(negedge pclk) begin
        if (rsp_valid === 1'b1) begin
            obs_q.push_back({rsp_rdata, rsp_err, rsp_timeout});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({psel, penable, cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 6'b001000) begin
            tests_failed++;
            $display("FAIL reset_ctrl psel/penable/cmd_ready/rsp_valid/err/tmo=%b expected 001000",
                     {psel, penable, cmd_ready, rsp_valid, rsp_err, rsp_timeout});
        end
        tests_run++;
        if ({paddr, pwrite, pwdata, rsp_rdata} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_data paddr=%0d pwrite=%b pwdata=%h rsp_rdata=%h expected all 0",
                     paddr, pwrite, pwdata, rsp_rdata);
        end
        preset = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        rsp_t e, o;
        slv_waits = 0; slv_never = 1'b0; slv_err = 1'b0; slv_rdata = 8'h99;
        drive_cmd(1'b1, 2'd2, 8'hA5);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_idle_ready cmd_ready=%b expected 1", cmd_ready);
        end
        tick();   // T+1: SETUP
        cmd_valid = 1'b0;
        tests_run++;
        if ({psel, penable, cmd_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL wr_setup psel/penable/cmd_ready=%b expected 100", {psel, penable, cmd_ready});
        end
        tick();   // T+2: ACCESS
        tests_run++;
        if ({psel, penable, paddr, pwrite, pwdata} !== {1'b1, 1'b1, 2'd2, 1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL wr_access psel=%b penable=%b paddr=%0d pwrite=%b pwdata=%h expected 1 1 2 1 a5",
                     psel, penable, paddr, pwrite, pwdata);
        end
        tick();   // T+3: response
        tests_run++;
        if ({rsp_valid, psel, penable} !== 3'b100) begin
            tests_failed++;
            $display("FAIL wr_rsp_latency rsp_valid/psel/penable=%b expected 100", {rsp_valid, psel, penable});
        end
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL wr_rsp_count got %0d responses expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL wr_rsp rdata/err/tmo=%h/%b/%b expected %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
            end
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_rsp_pulse rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait3();
        rsp_t e, o;
        int n;
        slv_waits = 3; slv_never = 1'b0; slv_err = 1'b0; slv_rdata = 8'h3C;
        drive_cmd(1'b0, 2'd3, 8'h11);
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        tick();   // SETUP
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (psel === 1'b1 && penable === 1'b1) begin
                n++;
                tests_run++;
                if (paddr !== 2'd3 || pwrite !== 1'b0 || rsp_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rd_hold paddr=%0d pwrite=%b rsp_valid=%b expected 3 0 0", paddr, pwrite, rsp_valid);
                end
            end else begin
                break;
            end
        end
        tests_run++;
        if (n != 4 || rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_wait_len access_cycles=%0d rsp_valid=%b expected 4 1", n, rsp_valid);
        end
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL rd_rsp_count got %0d responses expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rd_rsp rdata/err/tmo=%h/%b/%b expected %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
            end
        end
        tick();
    endtask

    task automatic test_slave_error();
        rsp_t e, o;
        slv_waits = 0; slv_never = 1'b0; slv_err = 1'b1; slv_rdata = 8'h77;
        drive_cmd(1'b0, 2'd1, 8'h00);
        exp_q.push_back({8'h77, 1'b1, 1'b0});
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick();
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL err_rsp_count got %0d responses expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL err_rsp rdata/err/tmo=%h/%b/%b expected %h/%b/%b", o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
            end
        end
        slv_err = 1'b0;
        tick();
    endtask

    // never_ready=1: full abort; otherwise pready arrives on the terminal cycle
    task automatic test_timeout(input logic never_ready);
        rsp_t e, o;
        int n;
        slv_never = never_ready; slv_waits = TO - 1; slv_err = 1'b0; slv_rdata = 8'h6D;
        drive_cmd(1'b0, 2'd0, 8'h00);
        if (never_ready) exp_q.push_back({8'h00, 1'b1, 1'b1});
        else             exp_q.push_back({8'h6D, 1'b0, 1'b0});
        tick();   // SETUP
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (psel === 1'b1 && penable === 1'b1) n++;
            else break;
        end
        tests_run++;
        if (n != TO || psel !== 1'b0 || rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_len(never=%b) access_cycles=%0d psel=%b rsp_valid=%b expected %0d 0 1",
                     never_ready, n, psel, rsp_valid, TO);
        end
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL timeout_rsp_count got %0d responses expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL timeout_rsp(never=%b) rdata/err/tmo=%h/%b/%b expected %h/%b/%b",
                         never_ready, o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
            end
        end
        slv_never = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        int c0, c1;
        logic psel_seen;
        slv_waits = 0; slv_never = 1'b0; slv_err = 1'b0; slv_rdata = 8'hC3;
        drive_cmd(1'b1, 2'd0, 8'h5A);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        tick();   // SETUP #1
        drive_cmd(1'b0, 2'd2, 8'h00);
        exp_q.push_back({8'hC3, 1'b0, 1'b0});
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_setup_ready cmd_ready=%b expected 0", cmd_ready);
        end
        tick();   // ACCESS #1 (completion)
        tests_run++;
        if ({psel, penable, cmd_ready, paddr, pwdata} !== {1'b1, 1'b1, 1'b1, 2'd0, 8'h5A}) begin
            tests_failed++;
            $display("FAIL b2b_access1 psel=%b penable=%b cmd_ready=%b paddr=%0d pwdata=%h expected 1 1 1 0 5a",
                     psel, penable, cmd_ready, paddr, pwdata);
        end
        tick();   // SETUP #2
        cmd_valid = 1'b0;
        tests_run++;
        if ({psel, penable, paddr, pwrite} !== {1'b1, 1'b0, 2'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_setup2 psel=%b penable=%b paddr=%0d pwrite=%b expected 1 0 2 0",
                     psel, penable, paddr, pwrite);
        end
        psel_seen = 1'b1;
        for (int i = 0; i < 10 && obs_q.size() < 2; i++) begin
            tick();
            if (obs_q.size() < 2 && psel !== 1'b1) psel_seen = 1'b0;
        end
        tests_run++;
        if (obs_q.size() != 2 || !psel_seen) begin
            tests_failed++;
            $display("FAIL b2b_rsp_count got %0d responses psel_held=%b expected 2 1", obs_q.size(), psel_seen);
        end else begin
            c0 = obs_cyc_q.pop_front(); c1 = obs_cyc_q.pop_front();
            tests_run++;
            if (c1 - c0 != 2) begin
                tests_failed++;
                $display("FAIL b2b_spacing rsp gap=%0d cycles expected 2", c1 - c0);
            end
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                tests_run++;
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp%0d rdata/err/tmo=%h/%b/%b expected %h/%b/%b",
                             k, o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        slv_never = 1'b1;
        drive_cmd(1'b0, 2'd3, 8'h00);
        tick();   // SETUP
        cmd_valid = 1'b0;
        tick();   // ACCESS, stalled
        tick();   // ACCESS, stalled
        preset = 1'b1;
        tick();
        tests_run++;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rst_mid psel/penable/cmd_ready/rsp_valid=%b expected 0010",
                     {psel, penable, cmd_ready, rsp_valid});
        end
        preset = 1'b0;
        slv_never = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (obs_q.size() != 0 || psel !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_norsp responses=%0d psel=%b expected 0 0", obs_q.size(), psel);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_slave_error();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_back_to_back();
        test_reset_mid_access();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain %0d expected responses never seen", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_apb_master_bridge

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB initiator. Converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward slaves such as the GPIO block. Returns read data and error status on a one-cycle response strobe. Sits between the local controller or test sequencer and the APB slave bus. Single outstanding transfer; back-to-back transfers are supported.

Parameters:
ADDR_W, 2, width of cmd_addr/paddr
DATA_W, 8, width of write/read data
TIMEOUT, 16, max ACCESS cycles with pready low before forced abort (>=2)

Ports:
pclk  in  1  bus clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled at completion, or timeout abort
rsp_timeout  out  1  set with rsp_valid when the transfer was aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (preset=1 at a pclk edge): state IDLE. All outputs 0 except cmd_ready, which is 1 in IDLE. Wait counter cleared. Reset mid-transfer drops psel/penable on the same edge; no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: cmd_ready=1. On accept, latch addr/write/wdata into paddr/pwrite/pwdata; go to SETUP.
  - SETUP: psel=1, penable=0. Lasts exactly one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata are held stable.
    - Completion cycle: pready=1, or wait counter reaches TIMEOUT-1 with pready=0.
    - On completion: capture prdata (reads only), err = pslverr | timeout.
    - If cmd_valid is also high on that cycle: accept the new command (cmd_ready=1 only on this ACCESS cycle) and go directly to SETUP; psel stays 1 and penable drops.
    - Otherwise go to IDLE.
- cmd_ready is combinational: (state==IDLE) | (state==ACCESS & completion).
- Response:
  - rsp_valid, rsp_rdata, rsp_err and rsp_timeout are registered and appear the cycle after the completion edge.
  - rsp_valid is high for exactly one cycle.
  - rsp_rdata is 0 for writes.
- Latency: accept at edge T, SETUP cycle T+1, ACCESS T+2. With zero-wait pready, rsp_valid is high in cycle T+3. Each pready-low cycle adds one.
- Wait counter:
  - Width clog2(TIMEOUT).
  - Clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - No wrap: the abort occurs before the counter would wrap.
- pslverr and prdata are ignored outside the completion cycle.
- If pready and the timeout terminal count occur together, pready wins: normal completion, rsp_timeout=0.
- pwdata is driven even for reads (holds the latched value); slaves ignore it.

Decomposition:
- Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS), APB_READ/APB_WRITE constants, default widths. Other APB blocks reuse it.
- Sub-module apb_wait_timer: counter with clear, enable and terminal-count output. Parameterised by TIMEOUT.

Test Plan:
- Write, zero wait: cmd write addr=2 wdata=8'hA5, slave pready=1 -> psel@T+1, penable@T+2 with paddr=2, pwdata=A5, pwrite=1; rsp_valid@T+3, rsp_err=0.
- Read with 3 wait states: addr=3, pready low for 3 ACCESS cycles, then prdata=8'h3C -> penable held 4 cycles, paddr stable; rsp_rdata=3C one cycle after pready.
- Slave error: read addr=1, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0.
- Timeout: pready never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Back-to-back: cmd_valid held with write addr=0 then read addr=2 -> second SETUP immediately follows first ACCESS (psel never drops); two rsp_valid pulses 2 cycles apart.
- Reset mid-ACCESS: preset=1 during wait state -> next cycle psel=penable=0, cmd_ready=1, no rsp_valid.
